// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths
// (common with the CPU data port) and the port-owner encoding.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  // Owner / winner encoding, also used for last_winner.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  // The port opposite to p; anything that is not A maps to A so that a
  // last_winner of B hands the next tie to A.
  function automatic logic [1:0] other_port(input logic [1:0] p);
    return (p == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/handshake signals
// driven by the requester and grant/read-return signals driven by the arbiter.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/data_mem_arbiter_arb_rr_pick.sv
// Round-robin winner selection with a bounded burst. The winner is a
// combinational function of the requests and the owner/burst/last_winner
// state held here; a sole requester always wins.
module arb_rr_pick
  import data_mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic [1:0] winner
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  logic [1:0] owner;
  logic [3:0] burst_cnt;
  logic [1:0] last_winner;

  // Saturating increment of the burst counter at the burst cap.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    if (c >= BURST_CAP) begin
      return BURST_CAP;
    end
    return c + 4'd1;
  endfunction

  // Pick this cycle's winner; nothing is granted while in reset.
  always_comb begin
    winner = OWN_NONE;
    if (!rst) begin
      if (req_a && !req_b) begin
        winner = OWN_A;
      end else if (req_b && !req_a) begin
        winner = OWN_B;
      end else if (req_a && req_b) begin
        if (owner == OWN_NONE) begin
          winner = other_port(last_winner);
        end else if (burst_cnt < BURST_CAP) begin
          winner = owner;
        end else begin
          winner = other_port(owner);
        end
      end
    end
  end

  // Track the current owner, its run length and the most recent winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      burst_cnt   <= 4'd0;
      last_winner <= OWN_B;
    end else if (winner != OWN_NONE) begin
      owner       <= winner;
      last_winner <= winner;
      if (winner == owner) begin
        burst_cnt <= sat_inc(burst_cnt);
      end else begin
        burst_cnt <= 4'd1;
      end
    end else begin
      owner     <= OWN_NONE;
      burst_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path (port A)
// and the host/debug loader (port B), one access per cycle. Grants are
// combinational; read data returns one cycle later tagged to its port.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_arbiter_if.slave    port_a,
  data_mem_arbiter_if.slave    port_b,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_we,
  input  logic [DATA_W-1:0]    mem_rdata
);

  logic [1:0] winner;
  logic       vld_a_p1;
  logic       vld_b_p1;

  arb_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .req_a  (port_a.req),
    .req_b  (port_b.req),
    .winner (winner)
  );

  assign port_a.gnt = (winner == OWN_A);
  assign port_b.gnt = (winner == OWN_B);

  // Steer the winning port onto the RAM; idle bus is all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (winner)
      OWN_A: begin
        mem_addr  = port_a.addr;
        mem_wdata = port_a.wdata;
        mem_we    = port_a.we;
      end
      OWN_B: begin
        mem_addr  = port_b.addr;
        mem_wdata = port_b.wdata;
        mem_we    = port_b.we;
      end
      default: ;
    endcase
  end

  // Stage p0 -> p1: remember which port's read is in flight in the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
    end else begin
      vld_a_p1 <= port_a.gnt && !port_a.we;
      vld_b_p1 <= port_b.gnt && !port_b.we;
    end
  end

  // A read in flight when reset arrives is dropped, so rvalid is also masked by rst.
  assign port_a.rvalid = vld_a_p1 && !rst;
  assign port_b.rvalid = vld_b_p1 && !rst;
  assign port_a.rdata  = mem_rdata;
  assign port_b.rdata  = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed stimulus, a grant-history model with
// a word-addressed memory image checked every cycle, and literal checks.
module tb_data_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) pa ();
  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) pb ();

  data_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .port_a    (pa),
    .port_b    (pb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM with a registered read port.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[int'(mem_addr)] = mem_wdata;
      mem_rdata <= mem_wdata;
    end else begin
      mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist holds the winner of every cycle since the last reset (0 none, 1 A, 2 B).
  int            hist [$];
  logic [DW-1:0] mdl_mem [int];
  logic          pend_a = 1'b0;
  logic          pend_b = 1'b0;
  logic [DW-1:0] pdat_a = '0;
  logic [DW-1:0] pdat_b = '0;

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : '0;
  endfunction

  function automatic int pick(input logic ra, input logic rb);
    int run;
    int prev;
    int last;
    if (ra && !rb) return 1;
    if (rb && !ra) return 2;
    if (!ra && !rb) return 0;
    run  = 0;
    prev = 0;
    last = 2;
    foreach (hist[i]) begin
      if (hist[i] != 0) last = hist[i];
      if (hist[i] != 0 && hist[i] == prev) run++;
      else if (hist[i] != 0) run = 1;
      else run = 0;
      prev = hist[i];
    end
    if (prev == 0) return 3 - last;
    return (run < MB) ? prev : 3 - prev;
  endfunction

  always @(negedge clk) begin
    int            w;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    w   = rst ? 0 : pick(pa.req, pb.req);
    ewe = (w == 1) ? pa.we    : (w == 2) ? pb.we    : 1'b0;
    ea  = (w == 1) ? pa.addr  : (w == 2) ? pb.addr  : '0;
    ed  = (w == 1) ? pa.wdata : (w == 2) ? pb.wdata : '0;
    chk("m_gnt_a", 32'(pa.gnt), 32'(w == 1));
    chk("m_gnt_b", 32'(pb.gnt), 32'(w == 2));
    chk("m_mem_we", 32'(mem_we), 32'(ewe));
    chk("m_mem_addr", 32'(mem_addr), 32'(ea));
    if (w != 0 || rst) chk("m_mem_wdata", mem_wdata, ed);
    chk("m_rvalid_a", 32'(pa.rvalid), 32'(pend_a && !rst));
    chk("m_rvalid_b", 32'(pb.rvalid), 32'(pend_b && !rst));
    if (pend_a && !rst) chk("m_rdata_a", pa.rdata, pdat_a);
    if (pend_b && !rst) chk("m_rdata_b", pb.rdata, pdat_b);
    // advance the model to the next cycle
    pend_a = (w == 1) && !ewe;
    pend_b = (w == 2) && !ewe;
    if (w != 0 && !ewe) begin
      pdat_a = mdl_rd(ea);
      pdat_b = mdl_rd(ea);
    end
    if (w != 0 && ewe) mdl_mem[int'(ea)] = ed;
    if (rst) hist.delete();
    else hist.push_back(w);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pa.req = r; pa.we = w; pa.addr = a; pa.wdata = d;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pb.req = r; pb.we = w; pb.addr = a; pb.wdata = d;
  endtask

  initial begin
    logic [15:0] seq;
    seq = 16'b1111000011110000;
    drv_a(1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) tick();
    settle();
    chk("rst_gnt_a", 32'(pa.gnt), 32'd0);
    chk("rst_rvalid_a", 32'(pa.rvalid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    rst = 1'b0;

    // Loader preloads two words through port B.
    drv_b(1'b1, 1'b1, 14'h0010, 32'hDEADBEEF);
    settle(); chk("pre_gnt_b", 32'(pb.gnt), 32'd1); tick();
    drv_b(1'b1, 1'b1, 14'h0020, 32'hCAFEF00D);
    settle(); tick();
    drv_b(1'b0, 1'b0, '0, '0);

    // Lone read from A.
    drv_a(1'b1, 1'b0, 14'h0010, '0);
    settle(); chk("t1_gnt_a", 32'(pa.gnt), 32'd1); chk("t1_gnt_b", 32'(pb.gnt), 32'd0); tick();
    drv_a(1'b0, 1'b0, '0, '0);
    settle();
    chk("t1_rvalid_a", 32'(pa.rvalid), 32'd1);
    chk("t1_rdata_a", pa.rdata, 32'hDEADBEEF);
    chk("t1_rvalid_b", 32'(pb.rvalid), 32'd0);
    tick();

    // Tie on the first cycle after reset goes to A.
    rst = 1'b1;
    settle(); chk("t2_rst_we", 32'(mem_we), 32'd0); tick();
    rst = 1'b0;
    drv_a(1'b1, 1'b0, 14'h0010, '0);
    drv_b(1'b1, 1'b0, 14'h0020, '0);
    settle(); chk("t2_gnt_a", 32'(pa.gnt), 32'd1); chk("t2_gnt_b0", 32'(pb.gnt), 32'd0); tick();
    drv_a(1'b0, 1'b0, '0, '0);
    settle(); chk("t2_gnt_b", 32'(pb.gnt), 32'd1); chk("t2_rdata_a", pa.rdata, 32'hDEADBEEF); tick();
    drv_b(1'b0, 1'b0, '0, '0);
    settle(); chk("t2_rvalid_b", 32'(pb.rvalid), 32'd1); chk("t2_rdata_b", pb.rdata, 32'hCAFEF00D); tick();

    // Sustained contention: bursts of MAX_BURST alternate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_a(1'b1, 1'b0, 14'h0010, '0);
    drv_b(1'b1, 1'b0, 14'h0020, '0);
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("t3_gnt_a", 32'(pa.gnt), 32'(seq[15-i]));
      chk("t3_excl", 32'(pa.gnt && pb.gnt), 32'd0);
      tick();
    end
    drv_a(1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, '0, '0);
    tick();

    // B write followed by an A read of the same word.
    drv_b(1'b1, 1'b1, 14'h0100, 32'h12345678);
    settle();
    chk("t4_mem_we", 32'(mem_we), 32'd1);
    chk("t4_mem_addr", 32'(mem_addr), 32'h100);
    chk("t4_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    drv_b(1'b0, 1'b0, '0, '0);
    drv_a(1'b1, 1'b0, 14'h0100, '0);
    settle(); chk("t4_gnt_a", 32'(pa.gnt), 32'd1); chk("t4_no_rvalid_b", 32'(pb.rvalid), 32'd0); tick();
    drv_a(1'b0, 1'b0, '0, '0);
    settle(); chk("t4_rvalid_a", 32'(pa.rvalid), 32'd1); chk("t4_rdata_a", pa.rdata, 32'h12345678); tick();

    // Reset right after a granted read drops the read.
    drv_a(1'b1, 1'b0, 14'h0010, '0);
    settle(); chk("t5_gnt_a", 32'(pa.gnt), 32'd1); tick();
    rst = 1'b1;
    drv_a(1'b1, 1'b1, 14'h0055, 32'hFFFF0000);
    settle();
    chk("t5_rvalid_a", 32'(pa.rvalid), 32'd0);
    chk("t5_gnt_a_rst", 32'(pa.gnt), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_mem_wdata", mem_wdata, 32'd0);
    tick();
    rst = 1'b0;
    drv_a(1'b1, 1'b0, 14'h0010, '0);
    drv_b(1'b1, 1'b0, 14'h0020, '0);
    settle(); chk("t5_tie_a", 32'(pa.gnt), 32'd1); chk("t5_rvalid_after", 32'(pa.rvalid), 32'd0); tick();
    drv_a(1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, '0, '0);
    tick();

    // A alone for 10 cycles, then B joins and wins at the burst cap.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drv_a(1'b1, 1'b1, AW'(14'h0200 + i), 32'hA5000000 | 32'(i));
      else drv_a(1'b1, 1'b0, AW'(14'h0200 + i - 1), '0);
      settle();
      chk("t6_gnt_a", 32'(pa.gnt), 32'd1);
      if (i == 2) chk("t6_rdata_a", pa.rdata, 32'hA5000000);
      tick();
    end
    drv_a(1'b1, 1'b0, 14'h0200, '0);
    drv_b(1'b1, 1'b0, 14'h0100, '0);
    settle(); chk("t6_gnt_b", 32'(pb.gnt), 32'd1); chk("t6_gnt_a_blk", 32'(pa.gnt), 32'd0); tick();
    drv_b(1'b0, 1'b0, '0, '0);
    settle(); chk("t6_gnt_a_back", 32'(pa.gnt), 32'd1); chk("t6_rdata_b", pb.rdata, 32'h12345678); tick();
    drv_a(1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
